// File: rtl/register_file_multiport_if.sv
`default_nettype none
// ============================================================================
// Module      : register_file_multiport_if
// Description : Read/write/busy-issue bundle between the pipeline and the
//               multiport register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface register_file_multiport_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2
);
    logic [READ_PORTS*ADDR_WIDTH-1:0] read_address;
    wire  [READ_PORTS*DATA_WIDTH-1:0] read_data;
    wire  [READ_PORTS-1:0]            read_busy;
    logic                             write_enable_a;
    logic [ADDR_WIDTH-1:0]            write_address_a;
    logic [DATA_WIDTH-1:0]            write_data_a;
    logic                             write_enable_b;
    logic [ADDR_WIDTH-1:0]            write_address_b;
    logic [DATA_WIDTH-1:0]            write_data_b;
    logic                             busy_set_enable;
    logic [ADDR_WIDTH-1:0]            busy_set_address;
    logic [ADDR_WIDTH:0]              busy_count;

    modport master (
        output read_address,
        input  read_data, read_busy,
        output write_enable_a, write_address_a, write_data_a,
        output write_enable_b, write_address_b, write_data_b,
        output busy_set_enable, busy_set_address,
        input  busy_count
    );

    modport slave (
        input  read_address,
        output read_data, read_busy,
        input  write_enable_a, write_address_a, write_data_a,
        input  write_enable_b, write_address_b, write_data_b,
        input  busy_set_enable, busy_set_address,
        output busy_count
    );
endinterface
`default_nettype wire

// File: rtl/register_file_multiport.sv
`default_nettype none
// ============================================================================
// Module      : register_file_multiport
// Description : Parametrised register file, N combinational read ports with
//               write bypass, two write lanes (B has priority), busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module register_file_multiport #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int READ_PORTS = 2,
    parameter int ZERO_REG   = 1
) (
    input  wire logic                  clock,
    input  wire logic                  reset_n,
    register_file_multiport_if.slave   bus
);
    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [c_DEPTH];
    logic [c_DEPTH-1:0]    r_busy;
    logic [ADDR_WIDTH:0]   r_busy_count;

    logic                  w_wr_a;
    logic                  w_wr_b;
    logic                  w_set;
    logic [c_DEPTH-1:0]    w_busy_next;
    logic [ADDR_WIDTH:0]   w_pop;

    // Address 0 is the only illegal target, and only when it is hardwired.
    assign w_wr_a = bus.write_enable_a  && ((ZERO_REG == 0) || (bus.write_address_a  != '0));
    assign w_wr_b = bus.write_enable_b  && ((ZERO_REG == 0) || (bus.write_address_b  != '0));
    assign w_set  = bus.busy_set_enable && ((ZERO_REG == 0) || (bus.busy_set_address != '0));

    // Set is applied last so a freshly issued producer wins over a retiring one.
    always_comb begin
        w_busy_next = r_busy;
        if (w_wr_a) w_busy_next[bus.write_address_a] = 1'b0;
        if (w_wr_b) w_busy_next[bus.write_address_b] = 1'b0;
        if (w_set)  w_busy_next[bus.busy_set_address] = 1'b1;
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < c_DEPTH; i++) begin
            w_pop = w_pop + {{ADDR_WIDTH{1'b0}}, w_busy_next[i]};
        end
    end

    // Lane B is written after lane A so it takes the slot on an address clash.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            if (w_wr_a) r_regs[bus.write_address_a] <= bus.write_data_a;
            if (w_wr_b) r_regs[bus.write_address_b] <= bus.write_data_b;
            r_busy       <= w_busy_next;
            r_busy_count <= w_pop;
        end
    end

    assign bus.busy_count = r_busy_count;

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_addr;
        logic                  w_zero;
        logic                  w_hit_a;
        logic                  w_hit_b;
        logic [DATA_WIDTH-1:0] w_data;

        assign w_addr  = bus.read_address[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_zero  = (ZERO_REG != 0) && (w_addr == '0);
        assign w_hit_a = bus.write_enable_a && (bus.write_address_a == w_addr);
        assign w_hit_b = bus.write_enable_b && (bus.write_address_b == w_addr);

        always_comb begin
            if (!reset_n || w_zero) w_data = '0;
            else if (w_hit_b)       w_data = bus.write_data_b;
            else if (w_hit_a)       w_data = bus.write_data_a;
            else                    w_data = r_regs[w_addr];
        end

        assign bus.read_data[p*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign bus.read_busy[p] = reset_n && !w_zero && r_busy[w_addr] && !(w_hit_a || w_hit_b);
    end
endmodule
`default_nettype wire

// File: tb/tb_register_file_multiport.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_file_multiport
// Description : Directed bench driving a 32x64/2-port and a 16x64/3-port
//               register file with the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_multiport;
    logic        clock;
    logic        reset_n;
    logic [3:0]  r_ra [3];
    logic        r_we_a, r_we_b, r_bs_en;
    logic [3:0]  r_wa_a, r_wa_b, r_bs_addr;
    logic [63:0] r_wd_a, r_wd_b;
    int          r_checks;
    int          r_errors;

    register_file_multiport_if #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .READ_PORTS(2)) bus0 ();
    register_file_multiport_if #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .READ_PORTS(3)) bus1 ();

    assign bus0.read_address     = {1'b0, r_ra[1], 1'b0, r_ra[0]};
    assign bus0.write_enable_a   = r_we_a;
    assign bus0.write_address_a  = {1'b0, r_wa_a};
    assign bus0.write_data_a     = r_wd_a;
    assign bus0.write_enable_b   = r_we_b;
    assign bus0.write_address_b  = {1'b0, r_wa_b};
    assign bus0.write_data_b     = r_wd_b;
    assign bus0.busy_set_enable  = r_bs_en;
    assign bus0.busy_set_address = {1'b0, r_bs_addr};

    assign bus1.read_address     = {r_ra[2], r_ra[1], r_ra[0]};
    assign bus1.write_enable_a   = r_we_a;
    assign bus1.write_address_a  = r_wa_a;
    assign bus1.write_data_a     = r_wd_a;
    assign bus1.write_enable_b   = r_we_b;
    assign bus1.write_address_b  = r_wa_b;
    assign bus1.write_data_b     = r_wd_b;
    assign bus1.busy_set_enable  = r_bs_en;
    assign bus1.busy_set_address = r_bs_addr;

    register_file_multiport #(.DATA_WIDTH(64), .ADDR_WIDTH(5), .READ_PORTS(2), .ZERO_REG(1)) u_dut0 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus0)
    );

    register_file_multiport #(.DATA_WIDTH(64), .ADDR_WIDTH(4), .READ_PORTS(3), .ZERO_REG(1)) u_dut1 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
        r_checks++;
        if (act !== exp) begin
            r_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Port p of both instances (the 2-port instance only has ports 0 and 1).
    task automatic check_rd(input string tag, input int p, input logic [63:0] d, input logic b);
        check_value($sformatf("%s_w4_p%0d_data", tag, p), bus1.read_data[p*64 +: 64], d);
        check_value($sformatf("%s_w4_p%0d_busy", tag, p), {63'd0, bus1.read_busy[p]}, {63'd0, b});
        if (p < 2) begin
            check_value($sformatf("%s_w5_p%0d_data", tag, p), bus0.read_data[p*64 +: 64], d);
            check_value($sformatf("%s_w5_p%0d_busy", tag, p), {63'd0, bus0.read_busy[p]}, {63'd0, b});
        end
    endtask

    task automatic check_all(input string tag, input logic [63:0] d, input logic b);
        for (int p = 0; p < 3; p++) check_rd(tag, p, d, b);
    endtask

    task automatic check_cnt(input string tag, input int exp);
        check_value({tag, "_w5_cnt"}, {58'd0, bus0.busy_count}, 64'(exp));
        check_value({tag, "_w4_cnt"}, {59'd0, bus1.busy_count}, 64'(exp));
    endtask

    task automatic set_ra(input logic [3:0] a);
        for (int p = 0; p < 3; p++) r_ra[p] = a;
    endtask

    task automatic idle();
        r_we_a  = 1'b0;
        r_we_b  = 1'b0;
        r_bs_en = 1'b0;
    endtask

    // Clock the current inputs in, drop enables, land just after the falling edge.
    task automatic step();
        @(posedge clock);
        #1 idle();
        @(negedge clock);
        #1;
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [63:0] d);
        r_we_a = 1'b1; r_wa_a = a; r_wd_a = d;
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [63:0] d);
        r_we_b = 1'b1; r_wa_b = a; r_wd_b = d;
    endtask

    task automatic bset(input logic [3:0] a);
        r_bs_en = 1'b1; r_bs_addr = a;
    endtask

    initial begin
        r_checks = 0;
        r_errors = 0;
        r_wa_a = '0; r_wd_a = '0; r_wa_b = '0; r_wd_b = '0; r_bs_addr = '0;
        idle();
        set_ra(4'd4);
        reset_n = 1'b0;
        wr_b(4'd4, 64'h5);
        #3;
        check_all("in_reset", 64'h0, 1'b0);
        check_cnt("in_reset", 0);
        idle();
        @(negedge clock);
        reset_n = 1'b1;
        step();

        for (int a = 0; a < 16; a++) begin
            set_ra(4'(a));
            #1 check_all($sformatf("post_reset_r%0d", a), 64'h0, 1'b0);
        end
        check_cnt("post_reset", 0);

        wr_a(4'd5, 64'h1234);
        step();
        set_ra(4'd5);
        #1 check_all("wr_a_r5", 64'h1234, 1'b0);
        wr_a(4'd5, 64'hAA);
        #1 check_all("bypass_a_r5", 64'hAA, 1'b0);
        step();
        check_all("stored_r5", 64'hAA, 1'b0);

        wr_a(4'd7, 64'h1);
        wr_b(4'd7, 64'h2);
        set_ra(4'd7);
        #1 check_all("bypass_ab_r7", 64'h2, 1'b0);
        step();
        check_all("stored_ab_r7", 64'h2, 1'b0);
        wr_a(4'd0, 64'hFF);
        set_ra(4'd0);
        #1 check_all("bypass_r0", 64'h0, 1'b0);
        step();
        check_all("stored_r0", 64'h0, 1'b0);

        r_ra[0] = 4'd5; r_ra[1] = 4'd7; r_ra[2] = 4'd9;
        #1;
        check_rd("mixed", 0, 64'hAA, 1'b0);
        check_rd("mixed", 1, 64'h2, 1'b0);
        check_rd("mixed", 2, 64'h0, 1'b0);

        bset(4'd9);
        step();
        set_ra(4'd9);
        #1 check_all("busy_r9", 64'h0, 1'b1);
        check_cnt("busy_r9", 1);
        wr_b(4'd9, 64'h9);
        #1 check_all("retire_b_r9", 64'h9, 1'b0);
        check_cnt("retire_b_r9_same", 1);
        step();
        check_cnt("retire_b_r9_next", 0);
        check_all("stored_r9", 64'h9, 1'b0);

        bset(4'd3);
        wr_a(4'd3, 64'h5);
        step();
        set_ra(4'd3);
        #1 check_all("set_wins_r3", 64'h5, 1'b1);
        check_cnt("set_wins_r3", 1);
        bset(4'd0);
        step();
        check_cnt("set_r0", 1);
        bset(4'd3);
        step();
        check_cnt("reset_busy_r3", 1);
        wr_a(4'd10, 64'hA0);
        step();
        check_cnt("clear_idle_r10", 1);
        set_ra(4'd10);
        #1 check_all("stored_r10", 64'hA0, 1'b0);
        bset(4'd11);
        step();
        check_cnt("set_r11", 2);
        wr_a(4'd3, 64'h33);
        wr_b(4'd11, 64'hBB);
        step();
        check_cnt("double_retire", 0);

        bset(4'd1); step();
        bset(4'd2); step();
        bset(4'd3); step();
        check_cnt("three_busy", 3);
        set_ra(4'd5);
        bset(4'd12);
        #2 reset_n = 1'b0;
        #1;
        check_cnt("async_reset", 0);
        check_all("async_reset_r5", 64'h0, 1'b0);
        idle();
        @(negedge clock);
        reset_n = 1'b1;
        step();
        check_cnt("after_async_reset", 0);
        set_ra(4'd7);
        #1 check_all("after_async_reset_r7", 64'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", r_checks, r_errors);
        $finish;
    end
endmodule
`default_nettype wire
